jtkcpu_shseq: RTL and testbench
===============================

JTKCPU_SHSEQ -- requirements
Module: jtkcpu_shseq

Interface
REQ-001 Parameter: CNTW, default 8, width of the shift-count input and internal step counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. The ports are named as the codebase names them, clk and rst; the polarity and synchronicity are fixed.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 cen  in  1  clock enable; all state, counter and data updates occur only on edges with cen=1.
REQ-006 start  in  1  request; sampled only in IDLE on a cen edge.
REQ-007 kind  in  3  0=LSR, 1=ASR, 2=ROR, 3=ASL, 4=ROL, 5..7=reserved.
REQ-008 len  in  1  1=16-bit operation, 0=8-bit operation on bits [7:0].
REQ-009 opnd  in  16  operand to shift.
REQ-010 cnt  in  CNTW  number of single-bit steps.
REQ-011 cc_in  in  8  condition codes, bit order {E,F,H,I,N,Z,V,C} (C=bit0).
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  high while in DONE.
REQ-014 rslt  out  16  shifted result.
REQ-015 cc_out  out  8  updated condition codes, same bit order as cc_in.

Function
REQ-016 FSM states: IDLE, RUN and DONE; busy=(RUN); done=(DONE).
REQ-017 IDLE with cen and start: latch acc=opnd, c=cc_in[0], v=0, cc_keep=cc_in, kind, len and count=cnt.
- Go to RUN if cnt!=0 and kind<=4; otherwise go to DONE.
REQ-018 RUN, per cen edge: perform one step and decrement count; when count equals 1 before the decrement, go to DONE.
REQ-019 DONE, next cen edge: go to IDLE. A start seen in DONE or RUN is ignored, not queued.
REQ-020 Latency: done is visible after exactly cnt+1 cen edges, counting the accepting edge. cnt=0 or a reserved kind gives 1 edge.
REQ-021 Step definitions use msb=15 when len=1 and msb=7 when len=0:
- LSR: c=acc[0]; shift right; acc[msb]=0.
- ASR: c=acc[0]; shift right; acc[msb] retained.
- ROR: acc[msb]=old c; c=acc[0].
- ASL: c=acc[msb]; shift left; acc[0]=0; v|=acc[msb]^acc[msb-1] (pre-shift).
- ROL: c=acc[msb]; shift left; acc[0]=old c; v|=acc[msb]^acc[msb-1] (pre-shift).
REQ-022 For len=0, acc[15:8] is never modified and rslt[15:8]=opnd[15:8].
REQ-023 Final flags when at least one step ran:
- C=c.
- N=acc[msb].
- Z=(acc[msb:0]==0).
- V=v for ASL/ROL; V=0 for LSR/ASR/ROR.
- E, F, H, I taken from cc_keep.
REQ-024 cnt=0 or a reserved kind: rslt=opnd and cc_out=cc_in as latched; no flag modified.
REQ-025 Counts of any size run the full cnt steps, with no saturation or early exit. Example: LSR 16-bit with cnt>=16 gives 0; ROR with 17 steps restores a 16-bit operand.
REQ-026 rslt and cc_out update only at the transition into DONE. They hold through IDLE until the next completed operation.
REQ-027 cen=0 freezes state, count, acc, c, v and all outputs, in any state.

Reset
REQ-028 rst low, at any time including mid-RUN: state=IDLE, busy=0, done=0, rslt=0, cc_out=0, count=0, acc=0, c=0, v=0.
REQ-029 After rst is released, the first start is accepted normally; no partial operation resumes.

Verification
REQ-030 LSR, len=1, opnd=0x8001, cnt=1, cc_in=0x00 -> done after 2 cen edges; rslt=0x4000; C=1, N=0, Z=0, V=0.
REQ-031 ASL, len=0, opnd=0x5540, cnt=2 -> rslt=0x5500; C=1, Z=1, N=0, V=1 (sticky from step 1).
REQ-032 ROR, len=1, opnd=0x0001, cc_in C=0, cnt=17 -> rslt=0x0001, C=0; busy high for 17 cen edges.
REQ-033 ASR, len=1, opnd=0x8000, cnt=20, cc_in=0xF0 -> rslt=0xFFFF; C=1, N=1, Z=0; cc_out[7:4]=0xF.
REQ-034 cnt=0 with kind=ASR, and separately kind=6 with cnt=5; opnd=0x1234, cc_in=0xA5 -> rslt=0x1234, cc_out=0xA5, done after 1 cen edge.
REQ-035 Robustness: cen held low for 3 clocks mid-RUN -> no progress. start pulsed during RUN -> ignored. rst low mid-RUN -> all outputs 0 in the same cycle, IDLE; a new start then completes correctly.

Source files
------------

// File: rtl/jtkcpu_shseq.sv
// Multi-cycle shift/rotate sequencer: one single-bit step per enabled clock,
// with condition-code generation on completion.
module jtkcpu_shseq #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            start,
    input  logic [2:0]      kind,
    input  logic            len,
    input  logic [15:0]     opnd,
    input  logic [CNTW-1:0] cnt,
    input  logic [7:0]      cc_in,
    output logic            busy,
    output logic            done,
    output logic [15:0]     rslt,
    output logic [7:0]      cc_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] K_LSR = 3'd0;
    localparam logic [2:0] K_ASR = 3'd1;
    localparam logic [2:0] K_ROR = 3'd2;
    localparam logic [2:0] K_ASL = 3'd3;
    localparam logic [2:0] K_ROL = 3'd4;

    logic [1:0]      state_q;
    logic [CNTW-1:0] count_q;
    logic [15:0]     acc_q;
    logic            c_q;
    logic            v_q;
    logic [7:0]      keep_q;
    logic [2:0]      kind_q;
    logic            len_q;
    logic [15:0]     rslt_q;
    logic [7:0]      cc_q;

    logic            msb_b;
    logic            msb1_b;
    logic            left;
    logic            top_in;
    logic            low_in;
    logic [15:0]     step_acc;
    logic            step_c;
    logic            step_v;
    logic            step_n;
    logic            step_z;
    logic [7:0]      fin_cc;
    logic            go;

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign rslt   = rslt_q;
    assign cc_out = cc_q;

    assign go = (cnt != '0) && (kind <= K_ROL);

    // One step of the latched operation; upper byte is untouched for 8-bit ops
    always_comb begin
        msb_b  = len_q ? acc_q[15] : acc_q[7];
        msb1_b = len_q ? acc_q[14] : acc_q[6];
        left   = 1'b0;
        top_in = 1'b0;
        low_in = 1'b0;
        case (kind_q)
            K_LSR: top_in = 1'b0;
            K_ASR: top_in = msb_b;
            K_ROR: top_in = c_q;
            K_ASL: left = 1'b1;
            K_ROL: begin
                left   = 1'b1;
                low_in = c_q;
            end
            default: top_in = 1'b0;
        endcase

        if (left) begin
            step_acc = len_q ? {acc_q[14:0], low_in}
                             : {acc_q[15:8], acc_q[6:0], low_in};
            step_c   = msb_b;
        end else begin
            step_acc = len_q ? {top_in, acc_q[15:1]}
                             : {acc_q[15:8], top_in, acc_q[7:1]};
            step_c   = acc_q[0];
        end
        step_v = v_q | (left & (msb_b ^ msb1_b));
        step_n = len_q ? step_acc[15] : step_acc[7];
        step_z = len_q ? (step_acc == 16'd0) : (step_acc[7:0] == 8'd0);
        fin_cc = {keep_q[7:4], step_n, step_z, left & step_v, step_c};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            keep_q  <= '0;
            kind_q  <= '0;
            len_q   <= 1'b0;
            rslt_q  <= '0;
            cc_q    <= '0;
        end else if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= opnd;
                        c_q     <= cc_in[0];
                        v_q     <= 1'b0;
                        keep_q  <= cc_in;
                        kind_q  <= kind;
                        len_q   <= len;
                        count_q <= cnt;
                        if (go) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                            rslt_q  <= opnd;
                            cc_q    <= cc_in;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q   <= step_acc;
                    c_q     <= step_c;
                    v_q     <= step_v;
                    count_q <= count_q - 1'b1;
                    if (count_q == CNTW'(1)) begin
                        state_q <= ST_DONE;
                        rslt_q  <= step_acc;
                        cc_q    <= fin_cc;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_shseq.sv
// Bench for jtkcpu_shseq: directed table, hand sequences for cen/start/reset
// corners, and randomized ops against an arithmetic reference model.
module tb_jtkcpu_shseq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        start;
    logic [2:0]  kind;
    logic        len;
    logic [15:0] opnd;
    logic [7:0]  cnt;
    logic [7:0]  cc_in;
    logic        busy;
    logic        done;
    logic [15:0] rslt;
    logic [7:0]  cc_out;

    int checks = 0;
    int errors = 0;

    jtkcpu_shseq #(.CNTW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .start  (start),
        .kind   (kind),
        .len    (len),
        .opnd   (opnd),
        .cnt    (cnt),
        .cc_in  (cc_in),
        .busy   (busy),
        .done   (done),
        .rslt   (rslt),
        .cc_out (cc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  k;
        logic        l;
        logic [15:0] op;
        logic [7:0]  n;
        logic [7:0]  cc;
        logic [15:0] er;
        logic [7:0]  ecc;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: shift an integer of width w bit by bit
    function automatic void model(input logic [2:0] k, input logic l,
                                  input logic [15:0] op, input int n,
                                  input logic [7:0] cc,
                                  output logic [15:0] r,
                                  output logic [7:0] co, output int lat);
        int w, mask, top, a, c, v, nc;
        w    = l ? 16 : 8;
        mask = (1 << w) - 1;
        top  = 1 << (w - 1);
        a    = int'(op) & mask;
        c    = int'(cc[0]);
        v    = 0;
        if (n == 0 || k > 3'd4) begin
            r   = op;
            co  = cc;
            lat = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            case (k)
                3'd0: begin c = a & 1; a = a >> 1; end
                3'd1: begin c = a & 1; a = (a >> 1) | (a & top); end
                3'd2: begin
                    nc = a & 1;
                    a  = (a >> 1) | (c != 0 ? top : 0);
                    c  = nc;
                end
                default: begin
                    nc = (a & top) != 0 ? 1 : 0;
                    if ((((a >> (w - 1)) ^ (a >> (w - 2))) & 1) != 0) v = 1;
                    a = ((a << 1) & mask) | ((k == 3'd4) ? c : 0);
                    c = nc;
                end
            endcase
        end
        r     = l ? a[15:0] : {op[15:8], a[7:0]};
        co    = cc;
        co[3] = (a & top) != 0;
        co[2] = (a == 0);
        co[1] = (k >= 3'd3) && (v != 0);
        co[0] = (c != 0);
        lat   = n + 1;
    endfunction

    task automatic run_op(input string name, input logic [2:0] k,
                          input logic l, input logic [15:0] op,
                          input logic [7:0] n, input logic [7:0] cc,
                          input logic [15:0] er, input logic [7:0] ecc,
                          input int lat, input bit rcen);
        int edges = 0;
        int bedges = 0;
        int guard = 0;
        @(negedge clk);
        kind = k; len = l; opnd = op; cnt = n; cc_in = cc;
        cen = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (!done && guard < 8 * (lat + 4)) begin
            cen = rcen ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (busy && cen) bedges++;
            @(negedge clk);
            if (cen) edges++;
            guard++;
        end
        chk({name, " done"}, done, 1);
        chk({name, " lat"}, edges, lat);
        chk({name, " busy"}, bedges, lat - 1);
        chk({name, " rslt"}, rslt, er);
        chk({name, " cc"}, cc_out, ecc);
        cen = 1'b1;
        @(negedge clk);
        chk({name, " idle"}, {busy, done}, 0);
        chk({name, " hold"}, {rslt, cc_out}, {er, ecc});
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  co;
        int          lat;
        int          edges;
        logic [2:0]  rk;
        logic        rl;
        logic [15:0] rop;
        logic [7:0]  rn;
        logic [7:0]  rcc;

        tbl[0] = '{3'd0, 1'b1, 16'h8001, 8'd1,  8'h00, 16'h4000, 8'h01, 2};
        tbl[1] = '{3'd3, 1'b0, 16'h5540, 8'd2,  8'h00, 16'h5500, 8'h07, 3};
        tbl[2] = '{3'd2, 1'b1, 16'h0001, 8'd17, 8'h00, 16'h0001, 8'h00, 18};
        tbl[3] = '{3'd1, 1'b1, 16'h8000, 8'd20, 8'hF0, 16'hFFFF, 8'hF9, 21};
        tbl[4] = '{3'd1, 1'b1, 16'h1234, 8'd0,  8'hA5, 16'h1234, 8'hA5, 1};
        tbl[5] = '{3'd6, 1'b1, 16'h1234, 8'd5,  8'hA5, 16'h1234, 8'hA5, 1};
        tbl[6] = '{3'd0, 1'b1, 16'hFFFF, 8'd16, 8'h00, 16'h0000, 8'h05, 17};
        tbl[7] = '{3'd4, 1'b0, 16'hAB81, 8'd1,  8'h01, 16'hAB03, 8'h03, 2};

        rst = 1'b0; cen = 1'b0; start = 1'b0;
        kind = '0; len = 1'b0; opnd = '0; cnt = '0; cc_in = '0;
        repeat (3) @(negedge clk);
        chk("reset", {busy, done, rslt, cc_out}, 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].k, tbl[i].l, tbl[i].op,
                   tbl[i].n, tbl[i].cc, tbl[i].er, tbl[i].ecc,
                   tbl[i].lat, 1'b0);

        // cen stall and ignored start during RUN
        @(negedge clk);
        kind = 3'd0; len = 1'b1; opnd = 16'h00F0; cnt = 8'd4; cc_in = 8'h00;
        cen = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cen = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall busy", {busy, done}, 2'b10);
        cen = 1'b1; start = 1'b1; opnd = 16'hFFFF; kind = 3'd6;
        @(negedge clk);
        start = 1'b0;
        edges = 3;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("stall lat", edges, 5);
        chk("stall rslt", rslt, 16'h000F);
        @(negedge clk);
        @(negedge clk);
        chk("no queued start", {busy, done}, 0);

        // reset mid-RUN
        cen = 1'b1; kind = 3'd3; len = 1'b1; opnd = 16'h1234;
        cnt = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid reset", {busy, done, rslt, cc_out}, 0);
        @(negedge clk);
        rst = 1'b1;
        model(3'd4, 1'b1, 16'hC3A5, 9, 8'h31, r, co, lat);
        run_op("post reset", 3'd4, 1'b1, 16'hC3A5, 8'd9, 8'h31,
               r, co, lat, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rk  = 3'($urandom_range(0, 7));
            rl  = 1'($urandom_range(0, 1));
            rop = 16'($urandom);
            rn  = ($urandom_range(0, 5) == 0) ? 8'd0
                                                : 8'($urandom_range(1, 40));
            rcc = 8'($urandom);
            model(rk, rl, rop, int'(rn), rcc, r, co, lat);
            run_op($sformatf("rnd%0d", i), rk, rl, rop, rn, rcc,
                   r, co, lat, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
